// File: rtl/noc_inject_arbiter_pkg.sv
// Shared types, flit-format constants and header construction for the NoC injection arbiter.
package noc_inject_arbiter_pkg;

    localparam int NOC_FLIT_SIZE  = 34;
    localparam int PREAMBLE_WIDTH = 2;
    localparam int YX_WIDTH       = 3;
    localparam int MSG_TYPE_WIDTH = 5;
    localparam int RESERVED_WIDTH = 8;
    localparam int ROUTING_WIDTH  = 5;
    localparam int PAYLOAD_WIDTH  = NOC_FLIT_SIZE - PREAMBLE_WIDTH;
    localparam int LEN_MAX_W      = 8;

    typedef logic [NOC_FLIT_SIZE-1:0]  noc_flit_t;
    typedef logic [PREAMBLE_WIDTH-1:0] noc_preamble_t;

    localparam noc_preamble_t PREAMBLE_HEADER = 2'b10;
    localparam noc_preamble_t PREAMBLE_TAIL   = 2'b01;
    localparam noc_preamble_t PREAMBLE_BODY   = 2'b00;
    localparam noc_preamble_t PREAMBLE_1FLIT  = 2'b11;

    // Header field positions, MSB first below the preamble; two spare bits sit above routing.
    localparam int ORIG_Y_LSB   = 29;
    localparam int ORIG_X_LSB   = 26;
    localparam int DST_Y_LSB    = 23;
    localparam int DST_X_LSB    = 20;
    localparam int MSG_TYPE_LSB = 15;
    localparam int RESERVED_LSB = 7;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } inj_state_t;

    typedef struct packed {
        logic [YX_WIDTH-1:0]       dst_y;
        logic [YX_WIDTH-1:0]       dst_x;
        logic [MSG_TYPE_WIDTH-1:0] msg_type;
        logic [RESERVED_WIDTH-1:0] reserved;
        logic [LEN_MAX_W-1:0]      len;
    } noc_inj_req_t;

    function automatic noc_preamble_t get_preamble(input noc_flit_t flit);
        return flit[NOC_FLIT_SIZE-1 -: PREAMBLE_WIDTH];
    endfunction

    // Routing bits: [4]=local [3]=east [2]=west [1]=south [0]=north, masked toward the destination.
    function automatic noc_flit_t create_header(
        input logic [YX_WIDTH-1:0]       local_y,
        input logic [YX_WIDTH-1:0]       local_x,
        input logic [YX_WIDTH-1:0]       remote_y,
        input logic [YX_WIDTH-1:0]       remote_x,
        input logic [MSG_TYPE_WIDTH-1:0] msg_type,
        input logic [RESERVED_WIDTH-1:0] reserved
    );
        noc_flit_t                h;
        logic [ROUTING_WIDTH-1:0] go_left;
        logic [ROUTING_WIDTH-1:0] go_right;
        logic [ROUTING_WIDTH-1:0] route;
        h = '0;
        h[NOC_FLIT_SIZE-1 -: PREAMBLE_WIDTH]           = PREAMBLE_HEADER;
        h[ORIG_Y_LSB   +: YX_WIDTH]                    = local_y;
        h[ORIG_X_LSB   +: YX_WIDTH]                    = local_x;
        h[DST_Y_LSB    +: YX_WIDTH]                    = remote_y;
        h[DST_X_LSB    +: YX_WIDTH]                    = remote_x;
        h[MSG_TYPE_LSB +: MSG_TYPE_WIDTH]              = msg_type;
        h[RESERVED_LSB +: RESERVED_WIDTH]              = reserved;
        go_right = (local_x < remote_x) ? 5'b01000 : 5'b10111;
        go_left  = (local_x > remote_x) ? 5'b00100 : 5'b11011;
        route    = (local_y < remote_y) ? 5'b01110 : 5'b01101;
        route    = route & go_left & go_right;
        if (local_y == remote_y && local_x == remote_x)
            route = 5'b10000;
        h[ROUTING_WIDTH-1:0] = route;
        return h;
    endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    int j;

    // Scan from the farthest candidate to the nearest so the nearest match wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ)
                j = j - NREQ;
            if (req[j]) begin
                grant_idx = IDX_W'(j);
                grant_any = 1'b1;
            end
        end
        if (grant_any)
            grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin sharing of one NoC injection port among NREQ requesters.
// Optional per-requester packet counters are enabled with NOC_INJ_PKT_CNT_EN.
//
// state   | meaning
// IDLE    | no packet in flight; arbitrate and accept header fields
// HEADER  | header flit presented, waiting for router accept
// PAYLOAD | forwarding granted requester's payload flits until tail
module noc_inject_arbiter
    import noc_inject_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int LEN_W = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [YX_WIDTH-1:0]                   local_y,
    input  logic [YX_WIDTH-1:0]                   local_x,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ-1:0][YX_WIDTH-1:0]         req_dst_y,
    input  logic [NREQ-1:0][YX_WIDTH-1:0]         req_dst_x,
    input  logic [NREQ-1:0][MSG_TYPE_WIDTH-1:0]   req_msg_type,
    input  logic [NREQ-1:0][RESERVED_WIDTH-1:0]   req_reserved,
    input  logic [NREQ-1:0][LEN_W-1:0]            req_len,
    input  logic [NREQ-1:0]                       pld_valid,
    input  logic [NREQ-1:0][PAYLOAD_WIDTH-1:0]    pld_data,
    output logic [NREQ-1:0]                       pld_ready,
    output logic                                  noc_out_valid,
    output logic [NOC_FLIT_SIZE-1:0]              noc_out_data,
    input  logic                                  noc_out_ready,
    output logic                                  busy,
    output logic [IDX_W-1:0]                      grant_id
`ifdef NOC_INJ_PKT_CNT_EN
    ,
    output logic [NREQ-1:0][15:0]                 pkt_cnt
`endif
);

    inj_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_q;
    noc_inj_req_t          req_q;
    logic [YX_WIDTH-1:0]   loc_y_q;
    logic [YX_WIDTH-1:0]   loc_x_q;
    logic [LEN_W-1:0]      rem;
    logic [NREQ-1:0]       arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  hdr_1flit;
    logic                  rem_last;
    noc_flit_t             hdr_flit;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    assign hdr_1flit = (req_q.len == '0);
    assign rem_last  = (rem == LEN_W'(1));
    assign busy      = (state != IDLE);
    assign grant_id  = grant_q;

    always_comb begin
        hdr_flit = create_header(loc_y_q, loc_x_q, req_q.dst_y, req_q.dst_x,
                                 req_q.msg_type, req_q.reserved);
        if (hdr_1flit)
            hdr_flit[NOC_FLIT_SIZE-1 -: PREAMBLE_WIDTH] = PREAMBLE_1FLIT;
    end

    // req_ready is also held low while reset is asserted so every output reads 0.
    always_comb begin
        req_ready     = '0;
        pld_ready     = '0;
        noc_out_valid = 1'b0;
        noc_out_data  = '0;
        case (state)
            IDLE: begin
                if (rst)
                    req_ready = arb_grant;
            end
            HEADER: begin
                noc_out_valid = 1'b1;
                noc_out_data  = hdr_flit;
            end
            PAYLOAD: begin
                noc_out_valid      = pld_valid[grant_q];
                pld_ready[grant_q] = noc_out_ready;
                noc_out_data       = {rem_last ? PREAMBLE_TAIL : PREAMBLE_BODY, pld_data[grant_q]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            req_q   <= '0;
            loc_y_q <= '0;
            loc_x_q <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_q        <= arb_idx;
                        rr_ptr         <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                        req_q.dst_y    <= req_dst_y[arb_idx];
                        req_q.dst_x    <= req_dst_x[arb_idx];
                        req_q.msg_type <= req_msg_type[arb_idx];
                        req_q.reserved <= req_reserved[arb_idx];
                        req_q.len      <= LEN_MAX_W'(req_len[arb_idx]);
                        loc_y_q        <= local_y;
                        loc_x_q        <= local_x;
                        state          <= HEADER;
                    end
                end
                HEADER: begin
                    if (noc_out_ready) begin
                        if (hdr_1flit) begin
                            state <= IDLE;
                        end else begin
                            rem   <= req_q.len[LEN_W-1:0];
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (pld_valid[grant_q] && noc_out_ready) begin
                        rem <= rem - 1'b1;
                        if (rem_last)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NOC_INJ_PKT_CNT_EN
    logic pkt_done;

    assign pkt_done = noc_out_ready &&
                      ((state == HEADER && hdr_1flit) ||
                       (state == PAYLOAD && pld_valid[grant_q] && rem_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pkt_cnt <= '0;
        else if (pkt_done)
            pkt_cnt[grant_q] <= pkt_cnt[grant_q] + 16'd1;
    end
`endif

endmodule
